tmds_encoder: RTL and testbench
===============================

Name: tmds_encoder

Overview:
- Single-channel DVI/HDMI TMDS 8b/10b encoder; directly upstream of the TMDS decoder on the transmit side.
- Converts one 8-bit pixel component plus its 2-bit control pair into a 10-bit DC-balanced, transition-minimised symbol, one symbol per pixel clock.
- Three instances (B/G/R) feed the serialiser; the encoder is the loopback source for decoder verification.

Parameters:
- None. Control token values come from the shared package.

Ports:
- clk         in   1   pixel clock; all state on rising edge
- rst         in   1   asynchronous, active-high reset
- de          in   1   video data enable; 1 = data period, 0 = control period
- controlCom  in   2   control pair {c1,c0}, used when de=0
- dataIn      in   8   pixel component, used when de=1
- dataTx      out  10  encoded TMDS symbol, bit 0 transmitted first
- disparity   out  5   signed running disparity after the symbol on dataTx (debug/verification)

Behaviour:
- Reset (async assert, sync release): dataTx=COM00 (10'b1101010100), disparity=0, stage-1 de=0, stage-1 ctrl=00, stage-1 q_m=0.
- Latency: exactly 2 clk from de/controlCom/dataIn to dataTx. Fully pipelined, no stalls, one symbol per cycle.
- Stage 1 (transition minimisation, registered):
  - n1 = popcount(dataIn).
  - If n1>4, or n1==4 with dataIn[0]==0: XNOR chain, q_m[0]=d[0], q_m[i]=q_m[i-1] XNOR d[i], q_m[8]=0.
  - Otherwise: XOR chain, q_m[8]=1.
  - Register q_m[8:0], de, controlCom.
- Stage 2 (DC balance), operating on the stage-1 registers. N1/N0 = ones/zeros in q_m[7:0]; cnt is the disparity register.
  - de=0: dataTx = COM00/COM01/COM10/COM11 for ctrl 00/01/10/11; cnt <= 0.
  - de=1, cnt==0 or N1==N0:
    - dataTx = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
    - cnt += q_m[8] ? (N1-N0) : (N0-N1).
  - de=1, (cnt>0 and N1>N0) or (cnt<0 and N0>N1):
    - dataTx = {1, q_m[8], ~q_m[7:0]}.
    - cnt += 2*q_m[8] + (N0-N1).
  - de=1, all other cases:
    - dataTx = {0, q_m[8], q_m[7:0]}.
    - cnt += -2*(~q_m[8]) + (N1-N0).
- Arithmetic: cnt is 5-bit two's complement. All terms are sign-extended before addition. |cnt| never exceeds 10; the bench asserts this, and any overflow is a bug.
- Boundaries:
  - de 1->0 mid-line: the first control symbol appears 2 cycles later and cnt clears in the same cycle.
  - de 0->1: the first data symbol is encoded from cnt=0.
  - controlCom is ignored when de=1; dataIn is ignored when de=0.
  - rst mid-stream: dataTx=COM00 and disparity=0 immediately; the pipeline contents are discarded.
  - No X propagation from dataIn during control periods: the stage-1 data path may load it, but it must not reach the output.

Decomposition:
- HDMIPackage holds the control token constants COM00..COM11, shared with the decoder, and a 10-bit symbol typedef.
- Natural sub-module: tmds_qm_stage, the combinational stage-1 XOR/XNOR selector plus popcount. It is reusable by a reference model.
- Popcount is a package function.

Test Plan:
- Reset: assert rst with arbitrary inputs -> dataTx=10'b1101010100 and disparity=0 while rst is high and on the first cycle after release.
- Control tokens: de=0, ctrl 00,01,10,11 on consecutive cycles -> two cycles later dataTx = 1101010100, 0010101011, 0101010100, 1010101011; disparity stays 0.
- Disparity walk: from cnt=0, de=1, dataIn=0x00 for 3 cycles -> dataTx = 0x100, 0x3FF, 0x100; disparity = -8, 2, -6.
- XNOR path: from cnt=0, de=1, dataIn=0xFF -> dataTx=0x200, disparity=-8.
- de toggle: data 0x00 x2, then de=0 ctrl=01 -> dataTx 0x100, 0x3FF, then 0010101011 with disparity 0; the next de=1 0x00 yields 0x100 again.
- Loopback random: 10k random bytes with random de bursts -> the decoder recovers every byte and every ctrl. A behavioural model matches dataTx and disparity every cycle, and |disparity|≤10 throughout.

Source files
------------

// File: rtl/tmds_encoder_pkg.sv
// Shared TMDS definitions: the symbol type, control tokens, the stage-2 encoding
// modes and a byte popcount. The decoder uses the same package.
package tmds_encoder_pkg;

   typedef logic [9:0] tmds_sym_t;

   localparam tmds_sym_t COM00 = 10'b1101010100;
   localparam tmds_sym_t COM01 = 10'b0010101011;
   localparam tmds_sym_t COM10 = 10'b0101010100;
   localparam tmds_sym_t COM11 = 10'b1010101011;

   // ENC_BAL: disparity neutral; ENC_INV: invert to pull back; ENC_PASS: send as is
   typedef enum logic [1:0] {
      ENC_CTRL = 2'd0,
      ENC_BAL  = 2'd1,
      ENC_INV  = 2'd2,
      ENC_PASS = 2'd3
   } enc_mode_t;

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < 8; i++) begin
         n = n + {3'b000, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/tmds_encoder_if.sv
// Encoder-facing signal bundle. There is no backpressure: de qualifies dataIn on
// every clock and one symbol leaves on dataTx every clock, two clocks later.
interface tmds_encoder_if;
   logic       de;
   logic [1:0] controlCom;
   logic [7:0] dataIn;
   logic [9:0] dataTx;
   logic [4:0] disparity;

   modport master (output de, controlCom, dataIn, input dataTx, disparity);
   modport slave  (input de, controlCom, dataIn, output dataTx, disparity);
endinterface

// File: rtl/tmds_qm_stage.sv
// Transition-minimising stage: picks the XOR or XNOR chain from the byte's
// popcount and returns the 9-bit q_m word (bit 8 set means XOR was used).
module tmds_qm_stage
   import tmds_encoder_pkg::*;
(
   input  logic [7:0] i_data,
   output logic [8:0] o_qm
);

   logic [3:0] w_n1;
   logic       w_use_xnor;
   logic [8:0] w_qm;

   always_comb begin
      w_n1       = popcount8(i_data);
      w_use_xnor = (w_n1 > 4'd4) || ((w_n1 == 4'd4) && !i_data[0]);
      w_qm       = '0;
      w_qm[0]    = i_data[0];
      for (int i = 1; i < 8; i++) begin
         w_qm[i] = w_use_xnor ? ~(w_qm[i-1] ^ i_data[i]) : (w_qm[i-1] ^ i_data[i]);
      end
      w_qm[8] = ~w_use_xnor;
   end

   assign o_qm = w_qm;

endmodule

// File: rtl/tmds_encoder.sv
// Single-channel TMDS 8b/10b encoder: registered q_m stage, then a DC-balance
// stage that tracks running disparity in a 5-bit two's-complement counter.
module tmds_encoder
   import tmds_encoder_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   tmds_encoder_if.slave  bus
);

   logic [8:0] w_qm;
   logic [8:0] r_qm;
   logic       r_de;
   logic [1:0] r_ctrl;
   tmds_sym_t  r_data_tx;
   logic [4:0] r_cnt;

   logic [3:0] w_n1;
   logic [4:0] w_diff;
   logic       w_cnt_pos;
   logic       w_cnt_neg;
   logic       w_diff_pos;
   logic       w_diff_neg;
   enc_mode_t  w_mode;
   tmds_sym_t  w_ctrl_sym;
   tmds_sym_t  w_sym;
   logic [4:0] w_cnt_next;

   tmds_qm_stage u_qm (
      .i_data (bus.dataIn),
      .o_qm   (w_qm)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_qm   <= '0;
         r_de   <= 1'b0;
         r_ctrl <= 2'b00;
      end else begin
         r_qm   <= w_qm;
         r_de   <= bus.de;
         r_ctrl <= bus.controlCom;
      end
   end

   // w_diff is N1-N0 = 2*N1-8; modulo-32 arithmetic keeps it correct as signed
   always_comb begin
      w_n1       = popcount8(r_qm[7:0]);
      w_diff     = {w_n1, 1'b0} - 5'd8;
      w_cnt_pos  = !r_cnt[4] && (r_cnt != '0);
      w_cnt_neg  = r_cnt[4];
      w_diff_pos = !w_diff[4] && (w_diff != '0);
      w_diff_neg = w_diff[4];

      if (!r_de)
         w_mode = ENC_CTRL;
      else if ((r_cnt == '0) || (w_diff == '0))
         w_mode = ENC_BAL;
      else if ((w_cnt_pos && w_diff_pos) || (w_cnt_neg && w_diff_neg))
         w_mode = ENC_INV;
      else
         w_mode = ENC_PASS;

      case (r_ctrl)
         2'b00:   w_ctrl_sym = COM00;
         2'b01:   w_ctrl_sym = COM01;
         2'b10:   w_ctrl_sym = COM10;
         default: w_ctrl_sym = COM11;
      endcase

      w_sym      = w_ctrl_sym;
      w_cnt_next = '0;
      case (w_mode)
         ENC_BAL: begin
            w_sym      = {~r_qm[8], r_qm[8], r_qm[8] ? r_qm[7:0] : ~r_qm[7:0]};
            w_cnt_next = r_cnt + (r_qm[8] ? w_diff : -w_diff);
         end
         ENC_INV: begin
            w_sym      = {1'b1, r_qm[8], ~r_qm[7:0]};
            w_cnt_next = r_cnt + {3'b000, r_qm[8], 1'b0} - w_diff;
         end
         ENC_PASS: begin
            w_sym      = {1'b0, r_qm[8], r_qm[7:0]};
            w_cnt_next = r_cnt - {3'b000, ~r_qm[8], 1'b0} + w_diff;
         end
         default: begin
            w_sym      = w_ctrl_sym;
            w_cnt_next = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data_tx <= COM00;
         r_cnt     <= '0;
      end else begin
         r_data_tx <= w_sym;
         r_cnt     <= w_cnt_next;
      end
   end

   assign bus.dataTx    = r_data_tx;
   assign bus.disparity = r_cnt;

endmodule

// File: tb/tb_tmds_encoder.sv
// Bench for tmds_encoder: directed token/data vectors with literal expectations,
// a behavioural encoder model, a loopback decoder and a long random burst run.
module tb_tmds_encoder;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   tmds_encoder_if bus ();

   tmds_encoder dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      int         due;
      logic [9:0] sym;
      int         disp;
      logic       de;
      logic [1:0] ctrl;
      logic [7:0] data;
      bit         has_lit;
      logic [9:0] lit_sym;
      int         lit_disp;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   m_cnt    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
      end
   endtask

   // Encoder written straight from the TMDS rules, with integer disparity.
   function automatic logic [9:0] model_encode(input logic de, input logic [1:0] ctrl,
                                               input logic [7:0] d, inout int cnt);
      int         n1, ones, zeros, qb;
      logic [8:0] q;
      logic [9:0] s;
      if (!de) begin
         cnt = 0;
         case (ctrl)
            2'd0:    s = 10'b1101010100;
            2'd1:    s = 10'b0010101011;
            2'd2:    s = 10'b0101010100;
            default: s = 10'b1010101011;
         endcase
      end else begin
         n1 = 0;
         for (int i = 0; i < 8; i++) n1 += int'(d[i]);
         q    = '0;
         q[0] = d[0];
         if (n1 > 4 || (n1 == 4 && d[0] == 1'b0)) begin
            for (int i = 1; i < 8; i++) q[i] = ~(q[i-1] ^ d[i]);
            q[8] = 1'b0;
         end else begin
            for (int i = 1; i < 8; i++) q[i] = q[i-1] ^ d[i];
            q[8] = 1'b1;
         end
         ones = 0;
         for (int i = 0; i < 8; i++) ones += int'(q[i]);
         zeros = 8 - ones;
         qb    = int'(q[8]);
         if (cnt == 0 || ones == zeros) begin
            s   = q[8] ? {2'b01, q[7:0]} : {2'b10, ~q[7:0]};
            cnt = cnt + (q[8] ? (ones - zeros) : (zeros - ones));
         end else if ((cnt > 0 && ones > zeros) || (cnt < 0 && zeros > ones)) begin
            s   = {1'b1, q[8], ~q[7:0]};
            cnt = cnt + 2 * qb + (zeros - ones);
         end else begin
            s   = {1'b0, q[8], q[7:0]};
            cnt = cnt - 2 * (1 - qb) + (ones - zeros);
         end
      end
      return s;
   endfunction

   function automatic void decode(input logic [9:0] s, output logic is_c,
                                  output logic [1:0] c, output logic [7:0] d);
      logic [7:0] w;
      is_c = 1'b1;
      c    = 2'd0;
      d    = 8'd0;
      case (s)
         10'b1101010100: c = 2'd0;
         10'b0010101011: c = 2'd1;
         10'b0101010100: c = 2'd2;
         10'b1010101011: c = 2'd3;
         default: begin
            is_c = 1'b0;
            w    = s[9] ? ~s[7:0] : s[7:0];
            d[0] = w[0];
            for (int i = 1; i < 8; i++) d[i] = s[8] ? (w[i] ^ w[i-1]) : ~(w[i] ^ w[i-1]);
         end
      endcase
   endfunction

   task automatic drive_now(input logic de, input logic [1:0] ctrl, input logic [7:0] d,
                            input bit has_lit, input logic [9:0] lit_sym, input int lit_disp);
      exp_t e;
      bus.de         = de;
      bus.controlCom = ctrl;
      bus.dataIn     = d;
      e.sym      = model_encode(de, ctrl, d, m_cnt);
      e.disp     = m_cnt;
      e.due      = cyc + 2;
      e.de       = de;
      e.ctrl     = ctrl;
      e.data     = d;
      e.has_lit  = has_lit;
      e.lit_sym  = lit_sym;
      e.lit_disp = lit_disp;
      if (has_lit) begin
         check_val("model_sym_vs_literal", int'(e.sym), int'(lit_sym));
         check_val("model_disp_vs_literal", e.disp, lit_disp);
      end
      exp_q.push_back(e);
   endtask

   task automatic drive(input logic de, input logic [1:0] ctrl, input logic [7:0] d,
                        input bit has_lit, input logic [9:0] lit_sym, input int lit_disp);
      @(posedge clk);
      #2;
      drive_now(de, ctrl, d, has_lit, lit_sym, lit_disp);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1;
      rst            = 1'b1;
      bus.de         = 1'($urandom_range(0, 1));
      bus.controlCom = 2'($urandom_range(0, 3));
      bus.dataIn     = 8'($urandom_range(0, 255));
      exp_q.delete();
      m_cnt = 0;
      #1;
      check_val("rst_async_dataTx", int'(bus.dataTx), int'(10'b1101010100));
      check_val("rst_async_disparity", int'($signed(bus.disparity)), 0);
      repeat (2) begin
         @(negedge clk);
         check_val("rst_held_dataTx", int'(bus.dataTx), int'(10'b1101010100));
         check_val("rst_held_disparity", int'($signed(bus.disparity)), 0);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive_now(1'b0, 2'b00, 8'($urandom_range(0, 255)), 1'b0, 10'd0, 0);
      @(negedge clk);
      check_val("rst_release_dataTx", int'(bus.dataTx), int'(10'b1101010100));
      check_val("rst_release_disparity", int'($signed(bus.disparity)), 0);
   endtask

   exp_t       e_cmp;
   logic       dec_is_c;
   logic [1:0] dec_c;
   logic [7:0] dec_d;
   int         dut_disp;

   always @(negedge clk) begin
      if (!rst && exp_q.size() > 0 && exp_q[0].due == cyc) begin
         e_cmp    = exp_q.pop_front();
         dut_disp = int'($signed(bus.disparity));
         check_val("model_dataTx", int'(bus.dataTx), int'(e_cmp.sym));
         check_val("model_disparity", dut_disp, e_cmp.disp);
         checks++;
         if (dut_disp > 10 || dut_disp < -10) begin
            failures++;
            $display("FAIL disparity_range: got %0d required within -10..10", dut_disp);
         end
         decode(bus.dataTx, dec_is_c, dec_c, dec_d);
         if (e_cmp.de)
            check_val("loopback_data", int'({dec_is_c, dec_d}), int'({1'b0, e_cmp.data}));
         else
            check_val("loopback_ctrl", int'({dec_is_c, dec_c}), int'({1'b1, e_cmp.ctrl}));
         if (e_cmp.has_lit) begin
            check_val("literal_dataTx", int'(bus.dataTx), int'(e_cmp.lit_sym));
            check_val("literal_disparity", dut_disp, e_cmp.lit_disp);
         end
      end
   end

   initial begin
      int  sent;
      int  len;
      int  guard;
      bit  did_rst;

      rst            = 1'b1;
      bus.de         = 1'b0;
      bus.controlCom = 2'b00;
      bus.dataIn     = 8'h00;
      do_reset();

      // control tokens
      drive(1'b0, 2'b00, 8'($urandom_range(0, 255)), 1'b1, 10'b1101010100, 0);
      drive(1'b0, 2'b01, 8'($urandom_range(0, 255)), 1'b1, 10'b0010101011, 0);
      drive(1'b0, 2'b10, 8'($urandom_range(0, 255)), 1'b1, 10'b0101010100, 0);
      drive(1'b0, 2'b11, 8'($urandom_range(0, 255)), 1'b1, 10'b1010101011, 0);

      // disparity walk from cnt=0
      drive(1'b1, 2'($urandom_range(0, 3)), 8'h00, 1'b1, 10'h100, -8);
      drive(1'b1, 2'($urandom_range(0, 3)), 8'h00, 1'b1, 10'h3FF, 2);
      drive(1'b1, 2'($urandom_range(0, 3)), 8'h00, 1'b1, 10'h100, -6);

      // de toggle mid-line
      drive(1'b0, 2'b00, 8'hA5, 1'b1, 10'b1101010100, 0);
      drive(1'b1, 2'b11, 8'h00, 1'b1, 10'h100, -8);
      drive(1'b1, 2'b10, 8'h00, 1'b1, 10'h3FF, 2);
      drive(1'b0, 2'b01, 8'h3C, 1'b1, 10'b0010101011, 0);
      drive(1'b1, 2'b01, 8'h00, 1'b1, 10'h100, -8);

      // XNOR path from cnt=0
      drive(1'b0, 2'b10, 8'hFF, 1'b1, 10'b0101010100, 0);
      drive(1'b1, 2'b00, 8'hFF, 1'b1, 10'h200, -8);

      // random bursts with one reset mid-stream
      sent    = 0;
      did_rst = 1'b0;
      while (sent < 10000) begin
         len = $urandom_range(1, 40);
         for (int i = 0; i < len; i++) begin
            drive(1'b1, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 1'b0, 10'd0, 0);
            sent++;
         end
         len = $urandom_range(1, 8);
         for (int i = 0; i < len; i++)
            drive(1'b0, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 1'b0, 10'd0, 0);
         if (!did_rst && sent > 5000) begin
            do_reset();
            did_rst = 1'b1;
         end
      end

      drive(1'b0, 2'b00, 8'h00, 1'b0, 10'd0, 0);
      guard = 0;
      while (exp_q.size() > 0 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      #1;
      checks++;
      if (exp_q.size() > 0) begin
         failures++;
         $display("FAIL drain: got %0d pending symbols expected 0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
